// File: rtl/mem_pkg.sv
// Shared definitions for the memory initiator slice.
//
// Holds the default address/data widths and response depth used by
// mem_initiator, plus the packed response-entry layout {addr, rdata} that the
// response FIFO stores (the FIFO itself is width-generic; this struct matches
// its entry layout for the default widths).
package mem_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 2;
    localparam int unsigned MEM_DATA_WIDTH = 8;
    localparam int unsigned MEM_RSP_DEPTH  = 2;

    // Address in the upper bits, read data in the lower bits.
    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] rdata;
    } rsp_entry_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous FIFO holding read responses.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset; empties the FIFO and zeroes storage
//   push_i       write push_data_i (ignored when full)
//   push_data_i  entry to store
//   pop_i        drop the head entry (ignored when empty)
//   head_o       current head entry, stable until popped
//   count_o      number of valid entries
//   empty_o      no valid entries
module mem_rsp_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign full    = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_initiator.sv
// Memory initiator: turns a valid/ready command stream into single-cycle memory
// strobes and returns read data through a credit-protected response FIFO.
//
// Pipeline: accept (E0) -> issue registers drive mem_* for E0..E1 -> read data
// arrives one clock after mem_rd_en is sampled and is captured into the FIFO at
// E2. Commands are only accepted while a FIFO slot is guaranteed for every read
// in flight, so the FIFO can never overflow.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_write/cmd_addr/cmd_wdata  command fields (1 = write)
//   mem_addr/mem_wdata          registered memory address / write data
//   mem_wr_en/mem_rd_en         registered one-cycle memory strobes
//   mem_rdata                   memory read data, valid one clock after mem_rd_en
//   rsp_valid/rsp_ready         read-response handshake
//   rsp_addr/rsp_rdata          address and data of the head response
//   busy                        strobe active, read in capture, or response held
module mem_initiator
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int unsigned RSP_DEPTH  = MEM_RSP_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned RsvW = CntW + 1;
    localparam int unsigned EntW = ADDR_WIDTH + DATA_WIDTH;

    // Issue stage
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;

    // Capture stage: a read whose strobe was sampled last edge
    logic                  cap_valid_q;
    logic [ADDR_WIDTH-1:0] cap_addr_q;

    logic                  cmd_accept;
    logic                  fifo_empty;
    logic [CntW-1:0]       fifo_count;
    logic [EntW-1:0]       fifo_head;
    logic [RsvW-1:0]       reserved;

    // Every read in either pipeline stage already owns a FIFO slot.
    assign reserved = RsvW'(fifo_count) + RsvW'(rd_en_q) + RsvW'(cap_valid_q);

    // Depends on registered state only; held low while reset is asserted.
    assign cmd_ready  = !reset && (reserved < RsvW'(RSP_DEPTH));
    assign cmd_accept = cmd_valid && cmd_ready;

    always_comb begin
        wr_en_d     = cmd_accept && cmd_write;
        rd_en_d     = cmd_accept && !cmd_write;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (cmd_accept) begin
            mem_addr_d  = cmd_addr;
            mem_wdata_d = cmd_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_addr_q  <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            cap_valid_q <= rd_en_q;
            cap_addr_q  <= mem_addr_q;
        end
    end

    mem_rsp_fifo #(
        .WIDTH (EntW),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (cap_valid_q),
        .push_data_i ({cap_addr_q, mem_rdata}),
        .pop_i       (rsp_ready),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr_en = wr_en_q;
    assign mem_rd_en = rd_en_q;

    assign rsp_valid = !fifo_empty;
    assign rsp_addr  = fifo_head[EntW-1:DATA_WIDTH];
    assign rsp_rdata = fifo_head[DATA_WIDTH-1:0];

    assign busy = wr_en_q || rd_en_q || cap_valid_q || !fifo_empty;

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 2, memory address width; DATA_WIDTH, default 8, data width; RSP_DEPTH, default 2, response FIFO entries (min 2).
REQ-002 SHALL have ports, one per line:
  clk  input  1  clock, all logic on rising edge
  reset  input  1  reset, asynchronous, active-high
  cmd_valid  input  1  command offered
  cmd_ready  output  1  command accepted when valid&&ready
  cmd_write  input  1  1=write, 0=read
  cmd_addr  input  ADDR_WIDTH  target address
  cmd_wdata  input  DATA_WIDTH  write data
  mem_addr  output  ADDR_WIDTH  memory address
  mem_wr_en  output  1  memory write strobe
  mem_rd_en  output  1  memory read strobe
  mem_wdata  output  DATA_WIDTH  memory write data
  mem_rdata  input  DATA_WIDTH  memory read data, valid one clock after mem_rd_en sampled
  rsp_valid  output  1  read response available
  rsp_ready  input  1  response consumed when valid&&ready
  rsp_addr  output  ADDR_WIDTH  address of the returned read
  rsp_rdata  output  DATA_WIDTH  returned read data
  busy  output  1  any command issued or response held

Function
REQ-003 Issue: command accepted at edge E0 SHALL drive mem_addr/mem_wdata and exactly one of mem_wr_en/mem_rd_en, all registered, for the single cycle E0..E1 only.
REQ-004 Strobes SHALL be 0 in any cycle following an edge with no accepted command; mem_addr/mem_wdata hold last value.
REQ-005 Read capture: a read whose mem_rd_en is sampled at E1 SHALL have mem_rdata and its address captured into the response FIFO at E2; rsp_valid high from E2 when FIFO was empty (accept-to-rsp_valid latency 2 clocks).
REQ-006 Back-to-back commands SHALL issue one per clock, in acceptance order; a read immediately after a write to the same address SHALL return the written data.
REQ-007 Credit: reserved = FIFO occupancy + reads in the two issue/capture stages; cmd_ready SHALL be 1 iff reserved < RSP_DEPTH, for reads and writes alike.
REQ-008 cmd_ready SHALL be combinational from registered state only, never from cmd_valid/cmd_write.
REQ-009 Simultaneous accept and response pop in one cycle SHALL leave reserved unchanged for a read and decrement it for a write.
REQ-010 Response FIFO SHALL never overflow; rsp_valid=0 when empty; rsp_addr/rsp_rdata SHALL be stable while rsp_valid&&!rsp_ready.
REQ-011 Responses SHALL emerge in read-issue order; writes produce no response.
REQ-012 busy SHALL be 1 whenever any strobe is asserted, a read is in capture stage, or FIFO non-empty.
REQ-013 Datapath SHALL be pure pass-through; no width conversion or arithmetic on data.

Reset
REQ-014 On reset assertion, all outputs SHALL go to 0 asynchronously: mem_* =0, rsp_valid=0, rsp_addr/rsp_rdata=0, busy=0; cmd_ready=1 after release.
REQ-015 Reset mid-operation SHALL drop in-flight reads and flush the FIFO; no response for any pre-reset command SHALL appear after release.
REQ-016 First command SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-017 A shared package mem_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults and a typedef for the response entry {addr, rdata}.
REQ-018 Response FIFO SHALL be a sub-module mem_rsp_fifo (synchronous, RSP_DEPTH entries, count output, async reset).

Verification
REQ-019 After reset, against the memory model (reset fill 0xFF): read addr 2 -> rsp_rdata=0xFF, rsp_addr=2, rsp_valid exactly 2 clocks after accept.
REQ-020 Write 0x5A to addr 1 then read addr 1 on the next clock -> one mem_wr_en cycle then one mem_rd_en cycle; rsp_rdata=0x5A.
REQ-021 Four back-to-back reads addr 0..3 with rsp_ready=0 -> cmd_ready drops after 2 accepts; releasing rsp_ready returns all 4 in order 0,1,2,3 with no loss.
REQ-022 Write 0x11,0x22,0x33 to addr 0,1,3 then read 3,1,0 with rsp_ready=1 -> responses 0x33,0x22,0x11, no response for writes.
REQ-023 Assert reset while 2 reads are in flight -> all outputs 0 immediately; after release rsp_valid stays 0 until a new read.
REQ-024 Random cmd/rsp backpressure, 1000 commands -> scoreboard matches every response, mem strobes one-hot per cycle, no FIFO overflow.
